// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion controller.
// One shared RotWord/SubWord/Rcon datapath produces one expanded word per cycle.
// Words land in a 44x32 buffer that the cipher core reads through a registered
// 128-bit round-key port.
module aes_key_sched_ctrl #(
    parameter int           NUM_ROUNDS   = 10,
    parameter logic [127:0] RD_RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    input  logic         rd_en,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_data,
    output logic         rd_valid,
    output logic         rd_err
);

    localparam int         NUM_WORDS = 4 * (NUM_ROUNDS + 1);
    localparam logic [5:0] LAST_IDX  = 6'(NUM_WORDS - 1);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXPAND,
        ST_DONE
    } state_e;

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_e              state_q, state_d;
    logic [5:0]          i_q, i_d;
    logic [7:0]          rcon_q, rcon_d;
    logic [31:0]         win_q [4];
    logic [31:0]         win_d [4];
    logic [NUM_ROUNDS:0] valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [127:0]        rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_err_q, rd_err_d;

    logic [31:0] key_mem [NUM_WORDS];
    logic [31:0] temp_word;
    logic [31:0] new_word;
    logic [15:0] valid_ext;
    logic [5:0]  rd_base;

    // Word datapath: win_q[0] is w[i-4], win_q[3] is w[i-1].
    always_comb begin
        if (i_q[1:0] == 2'd0) begin
            temp_word = sub_word({win_q[3][23:0], win_q[3][31:24]}) ^ {rcon_q, 24'h0};
        end else begin
            temp_word = win_q[3];
        end
        new_word = win_q[0] ^ temp_word;
    end

    // Next-state logic for the expansion FSM and the read port.
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        rcon_d     = rcon_q;
        win_d      = win_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = done_q;
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        rd_data_d  = rd_data_q;
        valid_ext  = 16'(valid_q);
        rd_base    = {rd_round, 2'b00};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                win_d[0]   = key_in[127:96];
                win_d[1]   = key_in[95:64];
                win_d[2]   = key_in[63:32];
                win_d[3]   = key_in[31:0];
                valid_d[0] = 1'b1;
                i_d        = 6'd4;
                rcon_d     = 8'h01;
                state_d    = ST_EXPAND;
            end
            ST_EXPAND: begin
                win_d[0] = win_q[1];
                win_d[1] = win_q[2];
                win_d[2] = win_q[3];
                win_d[3] = new_word;
                i_d      = i_q + 6'd1;
                if (i_q[1:0] == 2'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q[1:0] == 2'd3) begin
                    valid_d[i_q[5:2]] = 1'b1;
                end
                if (i_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    valid_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rd_en) begin
            if (rd_round <= 4'(NUM_ROUNDS) && valid_ext[rd_round]) begin
                rd_valid_d = 1'b1;
                rd_data_d  = {key_mem[rd_base], key_mem[rd_base | 6'd1],
                              key_mem[rd_base | 6'd2], key_mem[rd_base | 6'd3]};
            end else begin
                rd_err_d  = 1'b1;
                rd_data_d = RD_RESET_VAL;
            end
        end
    end

    // Control and output registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            i_q        <= '0;
            rcon_q     <= 8'h01;
            win_q      <= '{default: '0};
            valid_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= RD_RESET_VAL;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            rcon_q     <= rcon_d;
            win_q      <= win_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

    // Expanded-key buffer writes: four key words in LOAD, one new word per EXPAND cycle.
    // NOTE: the buffer has no reset; the per-round valid bits decide what may be read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_LOAD) begin
                key_mem[0] <= key_in[127:96];
                key_mem[1] <= key_in[95:64];
                key_mem[2] <= key_in[63:32];
                key_mem[3] <= key_in[31:0];
            end else if (state_q == ST_EXPAND) begin
                key_mem[i_q] <= new_word;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl: known-answer round keys, early and
// illegal reads, ignored restart, mid-expansion reset and back-to-back runs.
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] KEY1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY1_R2   = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] KEY1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] KEY2      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2_R1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] KEY2_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] ONES      = {128{1'b1}};

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic         rd_err;

    int vectors     = 0;
    int miscompares = 0;

    aes_key_sched_ctrl #(
        .NUM_ROUNDS  (10),
        .RD_RESET_VAL('0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .key_in  (key_in),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .rd_round(rd_round),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .rd_err  (rd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one read at the next rising edge and check the registered response.
    task automatic rd(input string tag, input logic [3:0] r, input logic exp_v,
                      input logic exp_e, input logic [127:0] exp_d);
        rd_en    = 1'b1;
        rd_round = r;
        @(negedge clk);
        rd_en = 1'b0;
        check({tag, "_valid"}, 128'(rd_valid), 128'(exp_v));
        check({tag, "_err"},   128'(rd_err),   128'(exp_e));
        check({tag, "_data"},  rd_data,        exp_d);
    endtask

    // Pulse start for the rising edge T; returns at the falling edge just after T.
    task automatic start_exp(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        key_in   = '0;
        rd_en    = 1'b0;
        rd_round = '0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_busy",     128'(busy),     128'(0));
        check("rst_done",     128'(done),     128'(0));
        check("rst_rd_valid", 128'(rd_valid), 128'(0));
        check("rst_rd_err",   128'(rd_err),   128'(0));
        check("rst_rd_data",  rd_data,        '0);
        rst = 1'b0;
        @(negedge clk);
        rd("rst_rd0", 4'd0, 1'b0, 1'b1, '0);

        // FIPS-197 A.1 with early reads; after start_exp we sit just after edge T
        start_exp(KEY1);
        repeat (4) @(negedge clk);
        rd("early_r1_t5", 4'd1, 1'b0, 1'b1, '0);
        rd("early_r1_t6", 4'd1, 1'b1, 1'b0, KEY1_R1);
        rd("early_r2_t7", 4'd2, 1'b0, 1'b1, '0);
        repeat (13) @(negedge clk);
        check("a1_busy_t20", 128'(busy), 128'(1));
        check("a1_done_t20", 128'(done), 128'(0));
        repeat (20) @(negedge clk);
        check("a1_done_t40", 128'(done), 128'(0));
        @(negedge clk);
        check("a1_done_t41", 128'(done), 128'(1));
        check("a1_busy_t41", 128'(busy), 128'(0));
        rd("a1_r0",  4'd0,  1'b1, 1'b0, KEY1);
        rd("a1_r1",  4'd1,  1'b1, 1'b0, KEY1_R1);
        rd("a1_r2",  4'd2,  1'b1, 1'b0, KEY1_R2);
        rd("a1_r10", 4'd10, 1'b1, 1'b0, KEY1_R10);
        @(negedge clk);
        check("rd_valid_pulse", 128'(rd_valid), 128'(0));

        // Out-of-range round indices
        rd("bad_r11", 4'd11, 1'b0, 1'b1, '0);
        rd("bad_r15", 4'd15, 1'b0, 1'b1, '0);
        @(negedge clk);
        check("rd_err_pulse", 128'(rd_err), 128'(0));

        // Restart from DONE, then a start with another key during EXPAND is ignored
        start_exp(KEY1);
        check("rs_done_drop", 128'(done), 128'(0));
        rd("rs_valid_clr", 4'd10, 1'b0, 1'b1, '0);
        start_exp(ONES);
        repeat (38) @(negedge clk);
        check("ign_done_t40", 128'(done), 128'(0));
        @(negedge clk);
        check("ign_done_t41", 128'(done), 128'(1));
        rd("ign_r1",  4'd1,  1'b1, 1'b0, KEY1_R1);
        rd("ign_r10", 4'd10, 1'b1, 1'b0, KEY1_R10);

        // Reset in the middle of an expansion, then expand the all-zero key
        start_exp(KEY1);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy",     128'(busy),     128'(0));
        check("mid_rst_done",     128'(done),     128'(0));
        check("mid_rst_rd_valid", 128'(rd_valid), 128'(0));
        check("mid_rst_rd_data",  rd_data,        '0);
        rst = 1'b0;
        rd("mid_rst_r0", 4'd0, 1'b0, 1'b1, '0);
        repeat (24) @(negedge clk);
        check("mid_rst_no_done", 128'(done), 128'(0));
        check("mid_rst_no_busy", 128'(busy), 128'(0));
        start_exp('0);
        repeat (40) @(negedge clk);
        check("zero_done_t40", 128'(done), 128'(0));
        @(negedge clk);
        check("zero_done_t41", 128'(done), 128'(1));
        rd("zero_r1",  4'd1,  1'b1, 1'b0, ZERO_R1);
        rd("zero_r10", 4'd10, 1'b1, 1'b0, ZERO_R10);

        // Back-to-back start from DONE with a new key
        start_exp(KEY2);
        check("b2b_done_drop", 128'(done), 128'(0));
        rd("b2b_valid_clr", 4'd1, 1'b0, 1'b1, '0);
        repeat (39) @(negedge clk);
        check("b2b_done_t40", 128'(done), 128'(0));
        @(negedge clk);
        check("b2b_done_t41", 128'(done), 128'(1));
        rd("b2b_r0",  4'd0,  1'b1, 1'b0, KEY2);
        rd("b2b_r1",  4'd1,  1'b1, 1'b0, KEY2_R1);
        rd("b2b_r10", 4'd10, 1'b1, 1'b0, KEY2_R10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
